// File: rtl/axi_boundary_write_splitter.sv
// ---------------------------------------------------------------------------
// axi_boundary_write_splitter
//
// Takes one write burst (start byte address + length) and its data beats from
// an upstream write master. It reissues the burst downstream as one or more
// sub-bursts so that no sub-burst crosses a 2^BOUNDARY_W-byte address
// boundary. It generates m_wlast for each sub-burst and pulses done once the
// whole burst has been written.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   s_cmd_*         upstream burst command (s_addr, s_len = beats-1)
//   s_w*            upstream data beats (valid/ready, data, strobes)
//   m_cmd_*         downstream sub-burst command (m_addr, m_len = beats-1)
//   m_w*            downstream data beats, plus m_wlast per sub-burst
//   done            one-cycle pulse after the final beat of the whole burst
//   busy            high whenever the block is not idle
// ---------------------------------------------------------------------------
module axi_boundary_write_splitter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int BOUNDARY_W = 12,
    parameter int LEN_W      = 8
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                s_cmd_valid,
    output logic                s_cmd_ready,
    input  logic [ADDR_W-1:0]   s_addr,
    input  logic [LEN_W-1:0]    s_len,

    input  logic                s_wvalid,
    output logic                s_wready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,

    output logic                m_cmd_valid,
    input  logic                m_cmd_ready,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [LEN_W-1:0]    m_len,

    output logic                m_wvalid,
    input  logic                m_wready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,

    output logic                done,
    output logic                busy
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    // Beat counts run up to 2^LEN_W, so they need one extra bit.
    localparam int CNT_W = LEN_W + 1;
    // Common width for comparing remaining beats against boundary room.
    localparam int CMP_W = (CNT_W > BOUNDARY_W + 1) ? CNT_W : BOUNDARY_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   cur_addr_reg, cur_addr_next;
    logic [CNT_W-1:0]    rem_reg, rem_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [CNT_W-1:0]    sub_reg, sub_next;
    logic                done_reg, done_next;
    // Keeps s_cmd_ready low for one cycle after reset is released.
    logic                rst_d_reg;

    logic [ADDR_W-1:0]   aligned;
    logic [BOUNDARY_W:0] room;
    logic [CMP_W-1:0]    rem_ext;
    logic [CMP_W-1:0]    room_ext;
    logic [CNT_W-1:0]    sub;
    logic                beat;

    // Beat-aligned start and the number of whole beats left before the next
    // boundary. For an address already on a boundary, room is the full
    // boundary size in beats, which is why the extra top bit is needed.
    always_comb begin
        aligned  = cur_addr_reg & ~ADDR_W'(BYTES - 1);
        room     = ({1'b1, {BOUNDARY_W{1'b0}}} - {1'b0, aligned[BOUNDARY_W-1:0]}) >> OFF_W;
        rem_ext  = CMP_W'(rem_reg);
        room_ext = CMP_W'(room);
        // room is only selected when it is <= rem, so the narrowing cast is lossless.
        sub      = (rem_ext < room_ext) ? rem_reg : CNT_W'(room);
    end

    assign beat = s_wvalid && m_wready;

    always_comb begin
        state_next    = state_reg;
        cur_addr_next = cur_addr_reg;
        rem_next      = rem_reg;
        cnt_next      = cnt_reg;
        sub_next      = sub_reg;
        done_next     = 1'b0;

        s_cmd_ready   = 1'b0;
        m_cmd_valid   = 1'b0;
        m_wvalid      = 1'b0;
        s_wready      = 1'b0;
        m_wlast       = 1'b0;
        m_addr        = cur_addr_reg;
        m_len         = LEN_W'(sub - CNT_W'(1));
        m_wdata       = s_wdata;
        m_wstrb       = s_wstrb;

        case (state_reg)
            IDLE: begin
                s_cmd_ready = ~rst_d_reg;
                if (s_cmd_valid && !rst_d_reg) begin
                    cur_addr_next = s_addr;
                    rem_next      = CNT_W'(s_len) + CNT_W'(1);
                    state_next    = ISSUE;
                end
            end

            ISSUE: begin
                m_cmd_valid = 1'b1;
                if (m_cmd_ready) begin
                    cnt_next   = sub;
                    sub_next   = sub;
                    state_next = DATA;
                end
            end

            DATA: begin
                m_wvalid = s_wvalid;
                s_wready = m_wready;
                m_wlast  = (cnt_reg == CNT_W'(1));
                if (beat) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        // The next sub-burst starts right after this one.
                        // It lands on a boundary whenever more data remains.
                        cur_addr_next = aligned + (ADDR_W'(sub_reg) << OFF_W);
                        rem_next      = rem_reg - sub_reg;
                        if (rem_reg == sub_reg) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end else begin
                            state_next = ISSUE;
                        end
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // While reset is held, nothing handshakes, whatever the state.
        if (rst) begin
            s_cmd_ready = 1'b0;
            m_cmd_valid = 1'b0;
            m_wvalid    = 1'b0;
            s_wready    = 1'b0;
            m_wlast     = 1'b0;
        end
    end

    assign done = done_reg && !rst;
    assign busy = (state_reg != IDLE) && !rst;

    always_ff @(posedge clk) begin
        rst_d_reg <= rst;
        if (rst) begin
            state_reg    <= IDLE;
            cur_addr_reg <= '0;
            rem_reg      <= '0;
            cnt_reg      <= '0;
            sub_reg      <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cur_addr_reg <= cur_addr_next;
            rem_reg      <= rem_next;
            cnt_reg      <= cnt_next;
            sub_reg      <= sub_next;
            done_reg     <= done_next;
        end
    end

endmodule

// File: tb/tb_axi_boundary_write_splitter.sv
// ---------------------------------------------------------------------------
// Bench for axi_boundary_write_splitter.
// Two instances: boundary 4 KB (index 0) and 64 B (index 1). Only the
// selected instance receives commands. A scoreboard holds the expected
// sub-burst commands and beats, and a monitor compares them on every
// downstream handshake.
// ---------------------------------------------------------------------------
module tb_axi_boundary_write_splitter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int LW = 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
    } cmd_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
        logic          fin;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          sel;
    logic          s_cmd_valid;
    logic [AW-1:0] s_addr;
    logic [LW-1:0] s_len;
    logic          s_wvalid;
    logic [DW-1:0] s_wdata;
    logic [SW-1:0] s_wstrb;
    logic          m_cmd_ready;
    logic          m_wready;

    logic [1:0]    o_s_cmd_ready, o_s_wready, o_m_cmd_valid, o_m_wvalid;
    logic [1:0]    o_m_wlast, o_done, o_busy, g_cmd_valid;
    logic [AW-1:0] o_m_addr  [2];
    logic [LW-1:0] o_m_len   [2];
    logic [DW-1:0] o_m_wdata [2];
    logic [SW-1:0] o_m_wstrb [2];

    assign g_cmd_valid[0] = s_cmd_valid && (sel == 1'b0);
    assign g_cmd_valid[1] = s_cmd_valid && (sel == 1'b1);

    axi_boundary_write_splitter #(
        .ADDR_W(AW), .DATA_W(DW), .BOUNDARY_W(12), .LEN_W(LW)
    ) dut_4k (
        .clk(clk), .rst(rst),
        .s_cmd_valid(g_cmd_valid[0]), .s_cmd_ready(o_s_cmd_ready[0]),
        .s_addr(s_addr), .s_len(s_len),
        .s_wvalid(s_wvalid), .s_wready(o_s_wready[0]),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .m_cmd_valid(o_m_cmd_valid[0]), .m_cmd_ready(m_cmd_ready),
        .m_addr(o_m_addr[0]), .m_len(o_m_len[0]),
        .m_wvalid(o_m_wvalid[0]), .m_wready(m_wready),
        .m_wdata(o_m_wdata[0]), .m_wstrb(o_m_wstrb[0]), .m_wlast(o_m_wlast[0]),
        .done(o_done[0]), .busy(o_busy[0])
    );

    axi_boundary_write_splitter #(
        .ADDR_W(AW), .DATA_W(DW), .BOUNDARY_W(6), .LEN_W(LW)
    ) dut_64 (
        .clk(clk), .rst(rst),
        .s_cmd_valid(g_cmd_valid[1]), .s_cmd_ready(o_s_cmd_ready[1]),
        .s_addr(s_addr), .s_len(s_len),
        .s_wvalid(s_wvalid), .s_wready(o_s_wready[1]),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .m_cmd_valid(o_m_cmd_valid[1]), .m_cmd_ready(m_cmd_ready),
        .m_addr(o_m_addr[1]), .m_len(o_m_len[1]),
        .m_wvalid(o_m_wvalid[1]), .m_wready(m_wready),
        .m_wdata(o_m_wdata[1]), .m_wstrb(o_m_wstrb[1]), .m_wlast(o_m_wlast[1]),
        .done(o_done[1]), .busy(o_busy[1])
    );

    // Outputs of the currently selected instance.
    logic          s_cmd_ready, s_wready, m_cmd_valid, m_wvalid, m_wlast, done, busy;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_len;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_wstrb;
    assign s_cmd_ready = o_s_cmd_ready[sel];
    assign s_wready    = o_s_wready[sel];
    assign m_cmd_valid = o_m_cmd_valid[sel];
    assign m_wvalid    = o_m_wvalid[sel];
    assign m_wlast     = o_m_wlast[sel];
    assign done        = o_done[sel];
    assign busy        = o_busy[sel];
    assign m_addr      = o_m_addr[sel];
    assign m_len       = o_m_len[sel];
    assign m_wdata     = o_m_wdata[sel];
    assign m_wstrb     = o_m_wstrb[sel];

    cmd_t  cmd_q[$];
    beat_t beat_q[$];
    beat_t in_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    bit    stall_en = 1'b0;
    bit    exp_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_beats(input logic [15:0] tag, input int n, input int c0,
                              input int c1, input int c2, input bit fin_en);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = {tag, 16'(i)};
            b.strb = 4'(i) ^ 4'hA;
            b.last = (i == c0) || (i == c1) || (i == c2);
            b.fin  = fin_en && (i == n - 1);
            beat_q.push_back(b);
            in_q.push_back(b);
        end
    endtask

    task automatic push_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l);
        cmd_t c;
        c.addr = a;
        c.len  = l;
        cmd_q.push_back(c);
    endtask

    // Upstream data source: presents the head of in_q and drops it once consumed.
    initial begin
        bit fire;
        s_wvalid = 1'b0;
        s_wdata  = '0;
        s_wstrb  = '0;
        forever begin
            @(negedge clk);
            fire = s_wvalid && s_wready;
            @(posedge clk);
            #1;
            if (fire && in_q.size() > 0) void'(in_q.pop_front());
            if (in_q.size() > 0) begin
                s_wvalid = 1'b1;
                s_wdata  = in_q[0].data;
                s_wstrb  = in_q[0].strb;
            end else begin
                s_wvalid = 1'b0;
            end
        end
    end

    // Downstream ready generator: always ready, or random stalls.
    initial begin
        m_cmd_ready = 1'b1;
        m_wready    = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_cmd_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            m_wready    = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor / scoreboard.
    initial begin
        bit            pc_stall = 1'b0, pw_stall = 1'b0;
        logic [AW-1:0] pc_addr;
        logic [LW-1:0] pc_len;
        logic [DW-1:0] pw_data;
        logic          pw_last;
        logic          in_data;
        cmd_t          c;
        beat_t         b;
        forever begin
            @(negedge clk);
            if (rst) begin
                pc_stall = 1'b0;
                pw_stall = 1'b0;
                exp_done = 1'b0;
            end else begin
                chk("done_pulse", 64'(done), 64'(exp_done));
                exp_done = 1'b0;
                if (pc_stall)
                    chk("cmd_hold", {m_cmd_valid, m_len, m_addr}, {1'b1, pc_len, pc_addr});
                if (pw_stall)
                    chk("beat_hold", {m_wvalid, m_wlast, m_wdata}, {1'b1, pw_last, pw_data});
                in_data = busy && !m_cmd_valid;
                chk("data_gate", {s_wready, m_wvalid},
                    {in_data && m_wready, in_data && s_wvalid});
                if (m_cmd_valid && m_cmd_ready) begin
                    if (cmd_q.size() == 0) begin
                        chk("cmd_unexpected", {m_addr, m_len}, 64'hFFFF_FFFF_FFFF);
                    end else begin
                        c = cmd_q.pop_front();
                        chk("cmd", {m_addr, m_len}, {c.addr, c.len});
                    end
                end
                if (m_wvalid && m_wready) begin
                    if (beat_q.size() == 0) begin
                        chk("beat_unexpected", 64'(m_wdata), 64'hFFFF_FFFF_FFFF);
                    end else begin
                        b = beat_q.pop_front();
                        chk("beat", {m_wlast, m_wstrb, m_wdata}, {b.last, b.strb, b.data});
                        exp_done = b.fin;
                    end
                end
                pc_stall = m_cmd_valid && !m_cmd_ready;
                pc_addr  = m_addr;
                pc_len   = m_len;
                pw_stall = m_wvalid && !m_wready;
                pw_data  = m_wdata;
                pw_last  = m_wlast;
            end
        end
    end

    task automatic check_quiet(input string name);
        chk(name, {s_cmd_ready, m_cmd_valid, m_wvalid, s_wready, m_wlast, done, busy}, 7'b0);
    endtask

    task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l);
        int k = 0;
        @(posedge clk);
        #1;
        s_addr      = a;
        s_len       = l;
        s_cmd_valid = 1'b1;
        do begin
            @(negedge clk);
            k++;
        end while (!s_cmd_ready && k < 100);
        if (!s_cmd_ready) chk("cmd_accept_timeout", 64'(s_cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        s_cmd_valid = 1'b0;
        @(negedge clk);
        chk("cmd_latency", 64'(m_cmd_valid), 64'd1);
    endtask

    task automatic wait_flush(input bit expect_idle);
        int k = 0;
        while ((cmd_q.size() > 0 || beat_q.size() > 0 || in_q.size() > 0 || exp_done) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 5000) chk("flush_timeout", 64'(beat_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        if (expect_idle) chk("idle_after", {busy, s_cmd_ready}, 2'b01);
    endtask

    initial begin
        rst         = 1'b1;
        sel         = 1'b0;
        s_cmd_valid = 1'b0;
        s_addr      = '0;
        s_len       = '0;
        repeat (3) begin
            @(negedge clk);
            check_quiet("in_reset");
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_quiet("after_reset");

        // Crosses 0x1000 after two beats.
        push_cmd(32'h0FF8, 8'd1);
        push_cmd(32'h1000, 8'd1);
        push_beats(16'hD001, 4, 1, 3, -1, 1'b1);
        send_cmd(32'h0FF8, 8'd3);
        wait_flush(1'b1);

        // Ends exactly on a boundary: one command, 256 beats.
        push_cmd(32'h0C00, 8'd255);
        push_beats(16'hD002, 256, 255, -1, -1, 1'b1);
        send_cmd(32'h0C00, 8'd255);
        wait_flush(1'b1);

        // Unaligned start with one beat of room.
        push_cmd(32'h0FFE, 8'd0);
        push_cmd(32'h1000, 8'd0);
        push_beats(16'hD003, 2, 0, 1, -1, 1'b1);
        send_cmd(32'h0FFE, 8'd1);
        wait_flush(1'b1);

        // 64-byte boundary: three sub-bursts.
        @(posedge clk);
        #1;
        sel = 1'b1;
        push_cmd(32'h0038, 8'd1);
        push_cmd(32'h0040, 8'd15);
        push_cmd(32'h0080, 8'd13);
        push_beats(16'hD004, 32, 1, 17, 31, 1'b1);
        send_cmd(32'h0038, 8'd31);
        wait_flush(1'b1);
        @(posedge clk);
        #1;
        sel = 1'b0;

        // First burst again under random downstream stalls.
        stall_en = 1'b1;
        push_cmd(32'h0FF8, 8'd1);
        push_cmd(32'h1000, 8'd1);
        push_beats(16'hD005, 4, 1, 3, -1, 1'b1);
        send_cmd(32'h0FF8, 8'd3);
        wait_flush(1'b0);
        stall_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_after_stall", {busy, s_cmd_ready}, 2'b01);

        // Reset in the middle of the second sub-burst's data phase.
        push_cmd(32'h0FF8, 8'd1);
        push_cmd(32'h1000, 8'd1);
        push_beats(16'hD006, 3, 1, -1, -1, 1'b0);
        send_cmd(32'h0FF8, 8'd3);
        wait_flush(1'b0);
        chk("mid_burst_busy", {busy, m_wlast}, 2'b11);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cmd_q.delete();
        beat_q.delete();
        in_q.delete();
        @(negedge clk);
        check_quiet("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_quiet("after_mid_reset");

        push_cmd(32'h2000, 8'd0);
        push_beats(16'hD007, 1, 0, -1, -1, 1'b1);
        send_cmd(32'h2000, 8'd0);
        wait_flush(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
